// File: rtl/multi_debounce.sv
// multi_debounce: CHANNELS independent button debouncers, each with a 2-FF
// synchroniser, a stability qualifier, a post-change lockout and registered
// press/release strobes. any_press is the same-cycle OR of the press strobes.
// Optional auto-repeat press strobes: define DEBOUNCE_REPEAT_EN.
module multi_debounce #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned STABLE_CYCLES  = 100,
    parameter int unsigned LOCKOUT_CYCLES = 5000000,
    parameter int unsigned REPEAT_DELAY   = 25000000,
    parameter int unsigned REPEAT_PERIOD  = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_state,
    output logic [CHANNELS-1:0] btn_press,
    output logic [CHANNELS-1:0] btn_release,
    output logic                any_press
);

    localparam int unsigned MAX_SL  = (STABLE_CYCLES > LOCKOUT_CYCLES) ? STABLE_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned MAX_RP  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned MAX_CNT = (MAX_SL > MAX_RP) ? MAX_SL : MAX_RP;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STABLE = 2'd0,
        ST_QUAL   = 2'd1,
        ST_LOCK   = 2'd2
    } state_e;

    state_e              state_q [CHANNELS];
    state_e              state_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q   [CHANNELS];
    logic [CNT_W-1:0]    cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [CHANNELS-1:0] flip_c;
    logic [CHANNELS-1:0] flip_press_c;

    // Per-channel qualify/lockout state machine; flip_c marks an accepted change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flip_c  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            unique case (state_q[i])
                ST_STABLE: begin
                    cnt_d[i] = '0;
                    if (sync2_q[i] != level_q[i]) begin
                        if (STABLE_CYCLES <= 1) begin
                            flip_c[i] = 1'b1;
                        end else begin
                            state_d[i] = ST_QUAL;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                end
                ST_QUAL: begin
                    if (sync2_q[i] == level_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == STABLE_LAST) begin
                        flip_c[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_LOCK: begin
                    if (cnt_q[i] == LOCK_LAST) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
            if (flip_c[i]) begin
                state_d[i] = (LOCKOUT_CYCLES == 0) ? ST_STABLE : ST_LOCK;
                cnt_d[i]   = '0;
            end
        end
    end

    assign level_d      = level_q ^ flip_c;
    assign flip_press_c = flip_c & ~level_q;
    assign release_d    = flip_c & level_q;

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0]    rep_cnt_q [CHANNELS];
    logic [CNT_W-1:0]    rep_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] rep_phase_q, rep_phase_d;
    logic [CHANNELS-1:0] rep_fire_c;

    // Auto-repeat timer: first interval REPEAT_DELAY, then REPEAT_PERIOD while held.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_fire_c  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (flip_c[i] || !level_q[i]) begin
                rep_cnt_d[i]   = '0;
                rep_phase_d[i] = 1'b0;
            end else if ((!rep_phase_q[i] && rep_cnt_q[i] == DELAY_LAST) ||
                         ( rep_phase_q[i] && rep_cnt_q[i] == PERIOD_LAST)) begin
                rep_fire_c[i]  = 1'b1;
                rep_cnt_d[i]   = '0;
                rep_phase_d[i] = 1'b1;
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_phase_q <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) rep_cnt_q[i] <= '0;
        end else begin
            rep_phase_q <= rep_phase_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign press_d = flip_press_c | rep_fire_c;
`else
    assign press_d = flip_press_c;
`endif

    // Synchronisers, FSM state, debounced level and strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign btn_state   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign any_press   = |press_q;

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: directed segment table, hand-written repeat
// sequence and randomized stimulus, all checked against a timestamp-based model.
module tb_multi_debounce;

    localparam int unsigned CH = 2;
    localparam int unsigned S  = 4;
    localparam int unsigned L  = 8;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn_in;
    logic [CH-1:0] btn_state;
    logic [CH-1:0] btn_press;
    logic [CH-1:0] btn_release;
    logic          any_press;

    always #5 clk = ~clk;

    multi_debounce #(
        .CHANNELS       (CH),
        .STABLE_CYCLES  (S),
        .LOCKOUT_CYCLES (L),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: an input delay of two edges, a run length of
    // consecutive mismatches, and the edge number until which a channel is deaf.
    int            e = 0;
    logic [CH-1:0] m_d1 = '0, m_d2 = '0;
    logic [CH-1:0] m_state = '0, m_press = '0, m_rel = '0;
    int            m_run [CH];
    int            m_lock_end [CH];
    int            m_press_edge [CH];

    // Segment bookkeeping for the directed table.
    logic [CH-1:0] prev_state = '0;
    logic [CH-1:0] seg_p, seg_r;

    typedef struct {
        logic          r;
        logic [CH-1:0] in;
        int            n;
        logic [CH-1:0] st;
        logic [CH-1:0] pm;
        logic [CH-1:0] rm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp, e);
    endtask

    task automatic model_edge(input logic r, input logic [CH-1:0] in);
        logic s;
        int   age;
        e++;
        m_press = '0;
        m_rel   = '0;
        for (int c = 0; c < int'(CH); c++) begin
            if (r) begin
                m_state[c]      = 1'b0;
                m_run[c]        = 0;
                m_lock_end[c]   = e;
                m_press_edge[c] = e;
            end else begin
                s = m_d2[c];
                if (e > m_lock_end[c]) begin
                    if (s != m_state[c]) begin
                        m_run[c]++;
                        if (m_run[c] == int'(S)) begin
                            m_state[c]    = s;
                            m_run[c]      = 0;
                            m_lock_end[c] = e + int'(L);
                            if (s) begin
                                m_press[c]      = 1'b1;
                                m_press_edge[c] = e;
                            end else begin
                                m_rel[c] = 1'b1;
                            end
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                age = e - m_press_edge[c];
`ifdef DEBOUNCE_REPEAT_EN
                if (m_state[c] && age >= int'(RD) && ((age - int'(RD)) % int'(RP)) == 0)
                    m_press[c] = 1'b1;
`else
                if (age < 0) m_press_edge[c] = e;
`endif
            end
        end
        if (r) begin
            m_d1 = '0;
            m_d2 = '0;
        end else begin
            m_d2 = m_d1;
            m_d1 = in;
        end
    endtask

    task automatic tick(input logic r, input logic [CH-1:0] in);
        rst    = r;
        btn_in = in;
        @(posedge clk);
        model_edge(r, in);
        #1;
        check("btn_state",   32'(btn_state),   32'(m_state));
        check("btn_press",   32'(btn_press),   32'(m_press));
        check("btn_release", 32'(btn_release), 32'(m_rel));
        check("any_press",   32'(any_press),   32'(|m_press));
        seg_p      = seg_p | (btn_press & ~prev_state);
        seg_r      = seg_r | btn_release;
        prev_state = btn_state;
    endtask

    function automatic vec_t mk(input logic r, input logic [CH-1:0] in, input int n,
                                input logic [CH-1:0] st, input logic [CH-1:0] pm,
                                input logic [CH-1:0] rm);
        vec_t v;
        v.r = r; v.in = in; v.n = n; v.st = st; v.pm = pm; v.rm = rm;
        return v;
    endfunction

    initial begin
        int            hold [CH];
        logic [CH-1:0] cur;
        logic          exp_p;
        vec_t          v;

        for (int c = 0; c < int'(CH); c++) begin
            m_run[c] = 0; m_lock_end[c] = 0; m_press_edge[c] = 0; hold[c] = 0;
        end
        rst    = 1'b1;
        btn_in = '0;

        // Directed segments: {rst, btn_in, cycles, state at end, accepted presses, releases}
        vecs.push_back(mk(1'b1, 2'b11,  3, 2'b00, 2'b00, 2'b00)); // reset with inputs high
        vecs.push_back(mk(1'b0, 2'b11,  4, 2'b00, 2'b00, 2'b00)); // edges 0..3: not yet
        vecs.push_back(mk(1'b0, 2'b11,  2, 2'b11, 2'b11, 2'b00)); // flips on edge 5
        vecs.push_back(mk(1'b0, 2'b11,  1, 2'b11, 2'b00, 2'b00)); // strobe lasted one cycle
        vecs.push_back(mk(1'b0, 2'b00, 10, 2'b11, 2'b00, 2'b00)); // through F+11: still held
        vecs.push_back(mk(1'b0, 2'b00,  1, 2'b00, 2'b00, 2'b11)); // falls at F+12
        vecs.push_back(mk(1'b0, 2'b00, 10, 2'b00, 2'b00, 2'b00)); // lockout expires
        for (int k = 0; k < 10; k++)                               // bounce, 2-cycle toggles
            vecs.push_back(mk(1'b0, (k % 2 == 0) ? 2'b01 : 2'b00, 2, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1'b0, 2'b01,  5, 2'b00, 2'b00, 2'b00)); // settled high, qualifying
        vecs.push_back(mk(1'b0, 2'b01,  1, 2'b01, 2'b01, 2'b00)); // accepted
        vecs.push_back(mk(1'b0, 2'b00, 11, 2'b01, 2'b00, 2'b00)); // locked then qualifying
        vecs.push_back(mk(1'b0, 2'b00,  1, 2'b00, 2'b00, 2'b01)); // released at F+12
        vecs.push_back(mk(1'b0, 2'b10, 20, 2'b10, 2'b10, 2'b00)); // ch1 pressed
        vecs.push_back(mk(1'b0, 2'b01,  5, 2'b10, 2'b00, 2'b00)); // both qualifying
        vecs.push_back(mk(1'b0, 2'b01,  1, 2'b01, 2'b01, 2'b10)); // simultaneous press/release
        vecs.push_back(mk(1'b0, 2'b01, 10, 2'b01, 2'b00, 2'b00)); // let lockout expire
        vecs.push_back(mk(1'b0, 2'b00,  4, 2'b01, 2'b00, 2'b00)); // ch0 mid-qualification
        vecs.push_back(mk(1'b1, 2'b00,  1, 2'b00, 2'b00, 2'b00)); // reset wins, no strobe
        vecs.push_back(mk(1'b0, 2'b01,  5, 2'b00, 2'b00, 2'b00)); // full requalification
        vecs.push_back(mk(1'b0, 2'b01,  1, 2'b01, 2'b01, 2'b00)); // press accepted at F

        foreach (vecs[i]) begin
            v     = vecs[i];
            seg_p = '0;
            seg_r = '0;
            for (int k = 0; k < v.n; k++) tick(v.r, v.in);
            check("seg_state",   32'(btn_state), 32'(v.st));
            check("seg_press",   32'(seg_p),     32'(v.pm));
            check("seg_release", 32'(seg_r),     32'(v.rm));
        end

        // Held after the press at F: repeats only at F+10, F+15, F+20, F+25.
        for (int k = 1; k <= 29; k++) begin
            tick(1'b0, 2'b01);
`ifdef DEBOUNCE_REPEAT_EN
            exp_p = (k >= int'(RD)) && (((k - int'(RD)) % int'(RP)) == 0);
`else
            exp_p = 1'b0;
`endif
            check("repeat_press0", 32'(btn_press[0]), 32'(exp_p));
        end

        // Randomized holds of short (bouncy) and long (accepted) lengths.
        cur = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < int'(CH); c++) begin
                if (hold[c] == 0) begin
                    cur[c]  = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(20, 40))
                                                          : int'($urandom_range(1, 6));
                end else begin
                    hold[c]--;
                end
            end
            tick($urandom_range(0, 499) == 0, cur);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
